// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-RAM load/fetch controller.
// Holds the state encoding and the parameter defaults used by the interface and the controller.
package imem_load_ctrl_pkg;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int          AW_DEF         = 7;
  localparam logic [31:0] FAULT_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundles the fetch, loader and RAM-side signals of the instruction-RAM controller.
// The slave modport is the controller's view; the master modport is the surrounding system.
interface imem_load_ctrl_if
  import imem_load_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ready;
  logic          if_valid;
  logic [31:0]   if_rdata;
  logic          if_fault;

  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, ld_start, ld_len, ld_valid, ld_data, mem_rdata,
    output if_ready, if_valid, if_rdata, if_fault,
           ld_ready, ld_busy, ld_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, ld_start, ld_len, ld_valid, ld_data, mem_rdata,
    input  if_ready, if_valid, if_rdata, if_fault,
           ld_ready, ld_busy, ld_done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_load_ctrl.sv
// Shares a single-port instruction RAM between a streaming program loader and CPU fetch,
// holding the core in reset while an image is being loaded.
//
// state  | meaning
// S_LOAD | core held in reset, loader words written to RAM at ptr
// S_RUN  | core running, fetches read RAM (or fault) with 1-cycle latency
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int          AW         = AW_DEF,
  parameter bit          BOOT_LOAD  = 1'b1,
  parameter logic [31:0] FAULT_WORD = FAULT_WORD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            cpu_rst_n,
  imem_load_ctrl_if.slave bus
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};
  localparam state_t      S_RST   = BOOT_LOAD ? S_LOAD : S_RUN;

  state_t      state_q, state_d;
  logic [AW:0] ptr_q, ptr_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] len_start;
  logic        done_q, done_d;
  logic        rvalid_q, rfault_q;
  logic        cpu_run_q;
  logic [31:0] rdata_hold_q;
  logic [31:0] rdata_now;
  logic        ld_acc, if_acc, in_range;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign len_start = (bus.ld_len > LEN_MAX) ? LEN_MAX : bus.ld_len;
  assign in_range  = (bus.if_addr[31:AW+2] == '0);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    len_d         = len_q;
    done_d        = 1'b0;
    ld_acc        = 1'b0;
    if_acc        = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.if_ready  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    case (state_q)
      S_LOAD: begin
        // a restart discards any word offered in the same cycle
        bus.ld_ready = !bus.ld_start;
        ld_acc       = bus.ld_valid && !bus.ld_start;
        if (ld_acc) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = ptr_q[AW-1:0];
          bus.mem_wdata = bus.ld_data;
          ptr_d         = ptr_q + LEN_ONE;
          if (ptr_q == len_q - LEN_ONE) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        bus.if_ready = !bus.ld_start;
        if_acc       = bus.if_req && !bus.ld_start;
        if (if_acc && in_range) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.if_addr[AW+1:2];
        end
      end
      default: ;
    endcase

    // an empty image completes immediately without touching the RAM
    if (bus.ld_start) begin
      ptr_d = '0;
      len_d = len_start;
      if (len_start == '0) begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end else begin
        state_d = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      ptr_q        <= '0;
      len_q        <= LEN_MAX;
      done_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rfault_q     <= 1'b0;
      cpu_run_q    <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      done_q    <= done_d;
      rvalid_q  <= if_acc;
      rfault_q  <= if_acc && !in_range;
      cpu_run_q <= (state_q == S_RUN);
      if (rvalid_q) begin
        rdata_hold_q <= rdata_now;
      end
    end
  end

  // RAM data is only meaningful in the cycle after a read; hold it otherwise
  assign rdata_now    = rfault_q ? FAULT_WORD : bus.mem_rdata;
  assign bus.if_rdata = rvalid_q ? rdata_now : rdata_hold_q;
  assign bus.if_valid = rvalid_q;
  assign bus.if_fault = rfault_q;
  assign bus.ld_busy  = (state_q == S_LOAD);
  assign bus.ld_done  = done_q;
  assign cpu_rst_n    = cpu_run_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed scenarios then randomized traffic, checked every cycle
// against an image/word-count model of the loader and a one-deep fetch response model.
module tb_imem_load_ctrl;

  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst_n;

  imem_load_ctrl_if #(.AW(AW)) bus ();

  imem_load_ctrl #(
    .AW        (AW),
    .BOOT_LOAD (1'b1),
    .FAULT_WORD(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_rst_n(cpu_rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  int vectors    = 0;
  int miscompares = 0;
  int we_count   = 0;

  // model: loader progress, expected RAM image, expected registered outputs
  bit          m_loading;
  int          m_idx;
  int          m_len;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          e_cpu, e_done, e_valid, e_fault, e_rknown;
  logic [31:0] e_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_loading = 1'b1;
    m_idx     = 0;
    m_len     = DEPTH;
    e_cpu     = 1'b0;
    e_done    = 1'b0;
    e_valid   = 1'b0;
    e_fault   = 1'b0;
    e_rdata   = 32'h0;
    e_rknown  = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  endtask

  task automatic model_update();
    bit start, facc, wr, oor;
    int len, w;
    if (!rst_n) return;
    start   = bus.ld_start;
    facc    = !m_loading && bus.if_req && !start;
    wr      = m_loading && !start && bus.ld_valid;
    e_cpu   = !m_loading;
    e_done  = 1'b0;
    e_valid = facc;
    e_fault = 1'b0;
    if (facc) begin
      oor     = (bus.if_addr >> (AW + 2)) != 0;
      w       = int'(bus.if_addr[AW+1:2]);
      e_fault = oor;
      if (oor) begin
        e_rdata  = 32'h0;
        e_rknown = 1'b1;
      end else begin
        e_rdata  = m_mem[w];
        e_rknown = m_known[w];
      end
    end
    if (start) begin
      len = (int'(bus.ld_len) > DEPTH) ? DEPTH : int'(bus.ld_len);
      if (len == 0) begin
        m_loading = 1'b0;
        e_done    = 1'b1;
      end else begin
        m_loading = 1'b1;
        m_idx     = 0;
        m_len     = len;
      end
    end else if (wr) begin
      m_mem[m_idx]   = bus.ld_data;
      m_known[m_idx] = 1'b1;
      m_idx++;
      if (m_idx == m_len) begin
        m_loading = 1'b0;
        e_done    = 1'b1;
      end
    end
  endtask

  task automatic compare();
    bit wr, rd, oor;
    chk1("cpu_rst_n", cpu_rst_n, e_cpu);
    chk1("ld_busy", bus.ld_busy, m_loading);
    chk1("ld_done", bus.ld_done, e_done);
    chk1("if_valid", bus.if_valid, e_valid);
    if (e_valid) chk1("if_fault", bus.if_fault, e_fault);
    if (e_rknown) chk("if_rdata", bus.if_rdata, e_rdata);
    chk1("ld_ready", bus.ld_ready, m_loading && !bus.ld_start);
    chk1("if_ready", bus.if_ready, !m_loading && !bus.ld_start);
    wr  = m_loading && !bus.ld_start && bus.ld_valid;
    oor = (bus.if_addr >> (AW + 2)) != 0;
    rd  = !m_loading && !bus.ld_start && bus.if_req && !oor;
    chk1("mem_en", bus.mem_en, wr || rd);
    chk1("mem_we", bus.mem_we, wr);
    if (wr) begin
      chk("mem_addr_wr", 32'(bus.mem_addr), 32'(m_idx));
      chk("mem_wdata", bus.mem_wdata, bus.ld_data);
    end
    if (rd) chk("mem_addr_rd", 32'(bus.mem_addr), 32'(bus.if_addr[AW+1:2]));
    if (bus.mem_we) we_count++;
  endtask

  task automatic sample();
    #2;
    compare();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cyc();
    sample();
    edge_step();
  endtask

  initial begin
    int rst_cnt;
    int r;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.ld_start = 1'b0;
    bus.ld_len   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0;
    m_reset();
    @(negedge clk);

    // reset values
    sample();
    chk1("rst_cpu", cpu_rst_n, 1'b0);
    chk1("rst_valid", bus.if_valid, 1'b0);
    chk("rst_rdata", bus.if_rdata, 32'h0);
    edge_step();
    rst_n = 1'b1;

    // load four words after boot
    bus.ld_start = 1'b1;
    bus.ld_len   = 8'(4);
    cyc();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hA0 + 32'(i);
      sample();
      chk("t1_waddr", 32'(bus.mem_addr), 32'(i));
      edge_step();
    end
    bus.ld_valid = 1'b0;
    sample();
    chk1("t1_done", bus.ld_done, 1'b1);
    chk1("t1_cpu_low", cpu_rst_n, 1'b0);
    edge_step();
    sample();
    chk1("t1_cpu_high", cpu_rst_n, 1'b1);
    chk1("t1_done_pulse", bus.ld_done, 1'b0);
    edge_step();

    // back-to-back fetches
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    cyc();
    bus.if_addr = 32'h4;
    sample();
    chk1("t2_v0", bus.if_valid, 1'b1);
    chk("t2_d0", bus.if_rdata, 32'hA0);
    edge_step();
    bus.if_addr = 32'h8;
    sample();
    chk("t2_d1", bus.if_rdata, 32'hA1);
    edge_step();
    bus.if_req = 1'b0;
    sample();
    chk("t2_d2", bus.if_rdata, 32'hA2);
    edge_step();
    sample();
    chk1("t2_idle", bus.if_valid, 1'b0);
    chk("t2_hold", bus.if_rdata, 32'hA2);
    edge_step();

    // out-of-range fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    sample();
    chk1("t3_mem_en", bus.mem_en, 1'b0);
    edge_step();
    bus.if_req = 1'b0;
    sample();
    chk1("t3_valid", bus.if_valid, 1'b1);
    chk1("t3_fault", bus.if_fault, 1'b1);
    chk("t3_rdata", bus.if_rdata, 32'h0);
    edge_step();

    // reload request collides with a fetch
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0;
    bus.ld_start = 1'b1;
    bus.ld_len   = 8'(2);
    sample();
    chk1("t4_if_ready", bus.if_ready, 1'b0);
    edge_step();
    bus.if_req   = 1'b0;
    bus.ld_start = 1'b0;
    sample();
    chk1("t4_no_valid", bus.if_valid, 1'b0);
    chk1("t4_busy", bus.ld_busy, 1'b1);
    edge_step();
    sample();
    chk1("t4_cpu_low", cpu_rst_n, 1'b0);
    edge_step();
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hB0 + 32'(i);
      cyc();
    end
    bus.ld_valid = 1'b0;
    sample();
    chk1("t4_done", bus.ld_done, 1'b1);
    edge_step();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h4;
    cyc();
    bus.if_addr = 32'h8;
    sample();
    chk("t4_new_word", bus.if_rdata, 32'hB1);
    edge_step();
    bus.if_req = 1'b0;
    sample();
    chk("t4_old_word", bus.if_rdata, 32'hA2);
    edge_step();

    // zero-length and over-length loads
    bus.ld_start = 1'b1;
    bus.ld_len   = 8'(0);
    sample();
    chk1("t5_zero_we", bus.mem_we, 1'b0);
    edge_step();
    bus.ld_start = 1'b0;
    sample();
    chk1("t5_zero_done", bus.ld_done, 1'b1);
    chk1("t5_zero_busy", bus.ld_busy, 1'b0);
    edge_step();
    bus.ld_start = 1'b1;
    bus.ld_len   = 8'(200);
    cyc();
    bus.ld_start = 1'b0;
    we_count     = 0;
    for (int i = 0; i < 132; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hC000_0000 | 32'(i);
      cyc();
    end
    bus.ld_valid = 1'b0;
    chk("t5_clamp_writes", 32'(we_count), 32'd128);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1FC;
    cyc();
    bus.if_req = 1'b0;
    sample();
    chk("t5_last_word", bus.if_rdata, 32'hC000_007F);
    edge_step();

    // reset in the middle of a load
    bus.ld_start = 1'b1;
    bus.ld_len   = 8'(4);
    cyc();
    bus.ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'hD0 + 32'(i);
      cyc();
    end
    rst_n = 1'b0;
    m_reset();
    sample();
    chk1("t6_cpu", cpu_rst_n, 1'b0);
    chk1("t6_valid", bus.if_valid, 1'b0);
    chk1("t6_done", bus.ld_done, 1'b0);
    chk("t6_rdata", bus.if_rdata, 32'h0);
    chk("t6_ptr", 32'(bus.mem_addr), 32'h0);
    edge_step();
    bus.ld_valid = 1'b0;
    cyc();
    rst_n = 1'b1;

    // randomized traffic
    rst_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!rst_n) begin
        rst_cnt--;
        if (rst_cnt <= 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_n   = 1'b0;
        rst_cnt = 2;
        m_reset();
      end
      bus.ld_start = ($urandom_range(0, m_loading ? 59 : 29) == 0);
      r = int'($urandom_range(0, 9));
      if (r == 0)      bus.ld_len = 8'(0);
      else if (r == 1) bus.ld_len = 8'($urandom_range(129, 255));
      else if (r == 2) bus.ld_len = 8'(128);
      else             bus.ld_len = 8'($urandom_range(1, 10));
      bus.ld_valid = ($urandom_range(0, 9) < 6);
      bus.ld_data  = $urandom;
      bus.if_req   = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 9));
      if (r == 0)      bus.if_addr = $urandom | 32'h200;
      else if (r == 1) bus.if_addr = 32'($urandom_range(0, DEPTH - 1) << 2) | 32'($urandom_range(0, 3));
      else             bus.if_addr = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
